sipo_deserializer: RTL
======================

Name: sipo_deserializer

Overview:
- Serial-in/parallel-out receiver; the counterpart of the team's parallel shift registers.
- Collects BITWIDTH serial bits into a word, in an order selected per word, and presents the word on a valid/ready output port.
- The assembly register and the output holding register are separate, so the next word keeps arriving while the current one waits.
- Sits between a bit-serial link front end and word-wide datapath logic.

Parameters:
- BITWIDTH, 8, data word width in bits (minimum 2).
- CNTW, $clog2(BITWIDTH+1), bit-counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- serIn  input  1  serial data bit
- serValid  input  1  serIn is valid this cycle; the bit is consumed at the clock edge
- dir  input  1  bit order: 1 = LSB-first (right shift, bits enter at MSB); 0 = MSB-first (left shift, bits enter at LSB)
- frameStart  input  1  synchronous abort of the partial word
- dataOut  output  BITWIDTH  assembled word (registered)
- dataValid  output  1  dataOut holds an unconsumed word
- dataReady  input  1  sink accepts dataOut at the clock edge when dataValid=1
- overrun  output  1  one-cycle pulse: a completed word was dropped
- busy  output  1  a partial word is in progress (bit count ≠ 0)

Behaviour:
- Reset (reset=0, asynchronous): shift register=0, bit count=0, latched dir=0, dataOut=0, dataValid=0, overrun=0, busy=0.
- Bit acceptance: every cycle with serValid=1 takes one bit; there is no back-pressure on the serial side.
- dir=0 (MSB-first): sr <= {sr[BITWIDTH-2:0], serIn}.
- dir=1 (LSB-first): sr <= {serIn, sr[BITWIDTH-1:1]}.
- dir latching: dir is sampled with bit 0 of each word (count==0 && serValid) and held internally for the rest of that word. Mid-word changes on the dir pin are ignored.
- Counter: increments per accepted bit. When the BITWIDTH-th bit is accepted:
  - the word is complete;
  - the count returns to 0;
  - the shift register needs no clearing.
- States: IDLE (count=0) and COLLECT (count 1..BITWIDTH-1). busy=1 in COLLECT.
- Word completion at edge N, output buffer free (dataValid=0, or dataValid&&dataReady at N):
  - dataOut <= completed word (including the bit taken at N);
  - dataValid=1 from the cycle after N.
  - Latency: last serial bit to dataValid is 1 cycle.
- Consume and complete at the same edge: dataOut is replaced by the new word and dataValid stays 1. No bubble, no overrun.
- Consume only: dataValid falls at the next edge; dataOut holds its last value.
- Word completion while dataValid=1 and dataReady=0:
  - the new word is dropped; dataOut and dataValid are unchanged;
  - overrun=1 for exactly one cycle.
- frameStart=1:
  - count <= 0 and the partial word is discarded.
  - If serValid=1 in the same cycle, that bit becomes bit 0 of a new word and dir is latched from it (count becomes 1).
  - The output buffer and dataValid are unaffected.
  - frameStart on a cycle that would complete a word: frameStart wins; no word is emitted and there is no overrun.
- dataOut is stable while dataValid=1 && dataReady=0.
- Reset asserted mid-word or mid-handshake: all state clears immediately and the pending word is lost.

Optional Feature:
- Macro: DESER_PARITY_EN.
- Defined: each word is BITWIDTH data bits followed by one even-parity bit. Total count reaches BITWIDTH+1; the parity bit is not shifted into the data.
  - Adds output parityErr (1 bit), registered alongside dataOut: 1 when XOR(data bits, parity bit) ≠ 0.
  - Reset value 0. Holds with dataOut; updates only when dataOut loads.
  - A word with a parity error is still delivered.
- Not defined: no parity bit and no parityErr port; words are exactly BITWIDTH bits.

Test Plan:
- Reset, then dir=0, serial 1,0,1,1,0,0,1,0 on consecutive cycles, dataReady=1 → dataOut=8'hB2, dataValid high one cycle after the 8th bit, high for 1 cycle.
- dir=1, same bit stream → dataOut=8'h4D. Toggle dir mid-word: result still 8'h4D.
- dataReady=0; send 8'hB2 then 8'h0F (MSB-first) → dataOut stays 8'hB2, overrun pulses once on the 8th bit of the second word. Raise dataReady → dataValid falls.
- Back-to-back words with dataReady asserted on the completion edge of the second word → dataValid stays 1, dataOut changes 8'hB2→8'h0F, no overrun.
- After 5 bits, frameStart=1 with serValid=1, serIn=1, then 7 more bits 0,0,0,0,0,0,0 (dir=0) → dataOut=8'h80, busy=0 after completion.
- Assert reset mid-word (3 bits in) and while dataValid=1 → all outputs 0 immediately. The next full word is assembled correctly from bit 0.

Source files
------------

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver: assembles BITWIDTH serial bits into a word and presents it on a
// valid/ready port. Optional DESER_PARITY_EN appends an even-parity bit per word and adds parityErr.
module sipo_deserializer #(
  parameter int BITWIDTH = 8,
  parameter int CNTW     = $clog2(BITWIDTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                serIn,
  input  logic                serValid,
  input  logic                dir,
  input  logic                frameStart,
  output logic [BITWIDTH-1:0] dataOut,
  output logic                dataValid,
  input  logic                dataReady,
  output logic                overrun,
`ifdef DESER_PARITY_EN
  output logic                parityErr,
`endif
  output logic                busy
);

`ifdef DESER_PARITY_EN
  localparam int LAST_BIT = BITWIDTH;
`else
  localparam int LAST_BIT = BITWIDTH - 1;
`endif
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(LAST_BIT);
  localparam logic [CNTW-1:0] ONE_CNT  = CNTW'(1);
  localparam logic [CNTW-1:0] ZERO_CNT = CNTW'(0);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

`ifdef DESER_PARITY_EN
  function automatic logic parity_err(input logic [BITWIDTH-1:0] data, input logic par);
    return ^{data, par};
  endfunction
`endif

  logic [BITWIDTH-1:0] sr_r, sr_nxt_s, shifted_s, word_s, data_r;
  logic [CNTW-1:0]     count_r, count_nxt_s;
  logic                dir_r, dir_nxt_s, dir_eff_s;
  logic                complete_s, buf_free_s;
  logic                valid_r, overrun_r;
  logic [0:0]          state_r;
`ifdef DESER_PARITY_EN
  logic                perr_r, perr_s;
`endif

  // Next-state of the assembly register, bit counter and latched bit order
  always_comb begin
    dir_eff_s   = (frameStart || (count_r == ZERO_CNT)) ? dir : dir_r;
    shifted_s   = dir_eff_s ? {serIn, sr_r[BITWIDTH-1:1]} : {sr_r[BITWIDTH-2:0], serIn};
    sr_nxt_s    = sr_r;
    count_nxt_s = count_r;
    dir_nxt_s   = dir_r;
    complete_s  = 1'b0;
    word_s      = shifted_s;
    buf_free_s  = !valid_r || dataReady;
`ifdef DESER_PARITY_EN
    perr_s      = 1'b0;
`endif
    if (frameStart) begin
      // An abort with a valid bit starts a fresh word with that bit
      if (serValid) begin
        sr_nxt_s    = shifted_s;
        count_nxt_s = ONE_CNT;
        dir_nxt_s   = dir;
      end else begin
        count_nxt_s = ZERO_CNT;
      end
    end else if (serValid) begin
      dir_nxt_s = dir_eff_s;
      if (count_r == LAST_CNT) begin
        complete_s  = 1'b1;
        count_nxt_s = ZERO_CNT;
`ifdef DESER_PARITY_EN
        word_s      = sr_r;
        perr_s      = parity_err(sr_r, serIn);
        sr_nxt_s    = sr_r;
`else
        sr_nxt_s    = shifted_s;
`endif
      end else begin
        count_nxt_s = count_r + ONE_CNT;
        sr_nxt_s    = shifted_s;
      end
    end else begin
      sr_nxt_s = sr_r;
    end
  end

  // Assembly-side state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_r    <= {BITWIDTH{1'b0}};
      count_r <= ZERO_CNT;
      dir_r   <= 1'b0;
      state_r <= ST_IDLE;
    end else begin
      sr_r    <= sr_nxt_s;
      count_r <= count_nxt_s;
      dir_r   <= dir_nxt_s;
      state_r <= (count_nxt_s != ZERO_CNT) ? ST_COLLECT : ST_IDLE;
    end
  end

  // Output holding register, handshake and overrun pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_r    <= {BITWIDTH{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
`ifdef DESER_PARITY_EN
      perr_r    <= 1'b0;
`endif
    end else begin
      overrun_r <= complete_s && !buf_free_s;
      if (complete_s && buf_free_s) begin
        data_r  <= word_s;
        valid_r <= 1'b1;
`ifdef DESER_PARITY_EN
        perr_r  <= perr_s;
`endif
      end else if (valid_r && dataReady) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign dataOut   = data_r;
  assign dataValid = valid_r;
  assign overrun   = overrun_r;
  assign busy      = (state_r == ST_COLLECT);
`ifdef DESER_PARITY_EN
  assign parityErr = perr_r;
`endif

endmodule
